rr_row_scheduler: RTL and testbench

RR_ROW_SCHEDULER -- requirements
Module: rr_row_scheduler

---
 rtl/rr_row_scheduler.sv | 134 +++++++++++++
 tb/tb_rr_row_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_row_scheduler.sv
// Round-robin row scheduler: grants one requesting row at a time, holds the
// grant until done, abandonment or timeout, then inserts a one-cycle release gap.
module rr_row_scheduler #(
    parameter int unsigned Lvl_ROWS    = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic [Lvl_ROWS-1:0]         req_i,
    input  logic                        done_i,
    output logic [Lvl_ROWS-1:0]         gnt_o,
    output logic                        gnt_valid_o,
    output logic [$clog2(Lvl_ROWS)-1:0] gnt_idx_o,
    output logic                        timeout_o
);

    localparam int unsigned IDX_W   = $clog2(Lvl_ROWS);
    // Keep the hold counter at least one bit wide when the timeout is disabled.
    localparam int unsigned CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [IDX_W-1:0]      ptr, ptr_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [Lvl_ROWS-1:0]   gnt_d;
    logic                  gnt_valid_d;
    logic [IDX_W-1:0]      gnt_idx_d;
    logic                  timeout_d;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic                  to_hit;
    logic                  busy_exit;
    logic [IDX_W-1:0]      ptr_after;

    // Pick the first requesting row at or above ptr, wrapping to row 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < Lvl_ROWS; i++) begin
            if (!win_found && req_i[IDX_W'((32'(ptr) + i) % Lvl_ROWS)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((32'(ptr) + i) % Lvl_ROWS);
            end
        end
    end

    // Release conditions of the current grant and the pointer that follows it.
    always_comb begin
        to_hit    = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TO_LAST));
        busy_exit = done_i || !req_i[gnt_idx_o] || to_hit;
        ptr_after = (gnt_idx_o == IDX_W'(Lvl_ROWS - 1)) ? '0 : gnt_idx_o + 1'b1;
    end

    // Next-state and next-output logic; outputs hold unless a state changes them.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        cnt_d       = cnt;
        gnt_d       = gnt_o;
        gnt_valid_d = gnt_valid_o;
        gnt_idx_d   = gnt_idx_o;
        timeout_d   = 1'b0;

        case (state)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_idx_d   = '0;
                if (enable_i && win_found) begin
                    state_d     = BUSY;
                    cnt_d       = '0;
                    gnt_d       = Lvl_ROWS'(1) << win_idx;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = win_idx;
                end
            end
            BUSY: begin
                if (cnt != {CNT_W{1'b1}}) begin
                    cnt_d = cnt + 1'b1;
                end
                if (busy_exit) begin
                    state_d     = RELEASE;
                    ptr_d       = ptr_after;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_idx_d   = '0;
                    timeout_d   = to_hit && !done_i;
                end
            end
            RELEASE: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_idx_d   = '0;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_idx_d   = '0;
            end
        endcase
    end

    // State, pointer, hold counter and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            gnt_idx_o   <= '0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            cnt         <= cnt_d;
            gnt_o       <= gnt_d;
            gnt_valid_o <= gnt_valid_d;
            gnt_idx_o   <= gnt_idx_d;
            timeout_o   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_row_scheduler.sv
// Directed bench for rr_row_scheduler: expected grant indices are queued as
// stimulus is applied and popped when the DUT raises a grant.
module tb_rr_row_scheduler;

    localparam int unsigned ROWS = 4;
    localparam int unsigned TO   = 16;

    logic            clk_i;
    logic            reset_i;
    logic            enable_i;
    logic [ROWS-1:0] req_i;
    logic            done_i;
    logic [ROWS-1:0] gnt_o;
    logic            gnt_valid_o;
    logic [1:0]      gnt_idx_o;
    logic            timeout_o;

    int tests;
    int fails;
    int exp_q[$];

    rr_row_scheduler #(
        .Lvl_ROWS    (ROWS),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .req_i       (req_i),
        .done_i      (done_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_idx_o   (gnt_idx_o),
        .timeout_o   (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One clock edge, then settle so inputs and samples sit away from the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},     32'(gnt_o),       32'd0);
        check({tag, "_valid"},   32'(gnt_valid_o), 32'd0);
        check({tag, "_idx"},     32'(gnt_idx_o),   32'd0);
        check({tag, "_timeout"}, 32'(timeout_o),   32'd0);
    endtask

    // Compare the current grant against the oldest queued expectation.
    task automatic check_grant(input string tag);
        int e;
        logic [ROWS-1:0] oh;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e] = 1'b1;
            check({tag, "_valid"}, 32'(gnt_valid_o), 32'd1);
            check({tag, "_gnt"},   32'(gnt_o),       32'(oh));
            check({tag, "_idx"},   32'(gnt_idx_o),   32'(e));
        end
    endtask

    // Bounded wait for the next grant; returns the number of edges taken.
    task automatic wait_grant(input string tag, output int n);
        n = 0;
        while (!gnt_valid_o && n < 10) begin
            step();
            n++;
        end
        if (!gnt_valid_o) begin
            check({tag, "_wait_expired"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            check_grant(tag);
        end
    endtask

    task automatic do_reset();
        reset_i  = 1'b0;
        enable_i = 1'b0;
        req_i    = '0;
        done_i   = 1'b0;
        step();
        step();
        reset_i  = 1'b1;
        enable_i = 1'b1;
    endtask

    task automatic finish_grant();
        req_i  = '0;
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        step();
        step();
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;

        // Reset state
        do_reset();
        check_zero("reset");

        // V1: first grant at ptr 0, then rotation past row 1
        req_i = 4'b1010;
        exp_q.push_back(1);
        step();
        check_grant("v1_first");
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check_zero("v1_release");
        exp_q.push_back(3);
        wait_grant("v1_second", n);
        finish_grant();

        // V2: all rows requesting, done after each grant
        do_reset();
        req_i = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int k = 0; k < 5; k++) begin
            wait_grant($sformatf("v2_grant%0d", k), n);
            if (k == 0) check("v2_latency", 32'(n), 32'd1);
            else        check($sformatf("v2_gap%0d", k), 32'(n >= 1 && n <= 2), 32'd1);
            done_i = 1'b1;
            step();
            done_i = 1'b0;
            check($sformatf("v2_drop%0d", k), 32'(gnt_o), 32'd0);
        end
        finish_grant();

        // V3: timeout on the 16th BUSY cycle; grant ignores enable and other rows
        do_reset();
        req_i = 4'b0100;
        exp_q.push_back(2);
        step();
        check_grant("v3_grant");
        enable_i = 1'b0;
        req_i    = 4'b0110;
        for (int i = 2; i <= 16; i++) begin
            step();
            check($sformatf("v3_hold%0d", i), 32'(gnt_o), 32'b0100);
            check($sformatf("v3_noto%0d", i), 32'(timeout_o), 32'd0);
        end
        enable_i = 1'b1;
        step();
        check("v3_timeout", 32'(timeout_o), 32'd1);
        check("v3_gnt_off", 32'(gnt_o), 32'd0);
        check("v3_idx_off", 32'(gnt_idx_o), 32'd0);
        req_i = 4'b1111;
        step();
        check("v3_pulse_end", 32'(timeout_o), 32'd0);
        exp_q.push_back(3);
        wait_grant("v3_ptr3", n);
        finish_grant();

        // V4: done coincides with timeout condition
        do_reset();
        req_i = 4'b0001;
        exp_q.push_back(0);
        step();
        check_grant("v4_grant");
        for (int i = 2; i <= 16; i++) begin
            step();
            check($sformatf("v4_hold%0d", i), 32'(gnt_o), 32'b0001);
        end
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check("v4_no_timeout", 32'(timeout_o), 32'd0);
        check("v4_gnt_off", 32'(gnt_o), 32'd0);
        step();
        check("v4_no_timeout_late", 32'(timeout_o), 32'd0);
        req_i = 4'b1111;
        exp_q.push_back(1);
        wait_grant("v4_next", n);
        finish_grant();

        // V5: granted row abandons its request
        do_reset();
        req_i = 4'b1000;
        exp_q.push_back(3);
        step();
        check_grant("v5_grant");
        step();
        step();
        check("v5_hold", 32'(gnt_o), 32'b1000);
        req_i = 4'b0000;
        step();
        check("v5_gnt_off", 32'(gnt_o), 32'd0);
        check("v5_no_timeout", 32'(timeout_o), 32'd0);
        req_i = 4'b0011;
        exp_q.push_back(0);
        wait_grant("v5_wrap", n);
        finish_grant();

        // V6: reset during BUSY, enable low blocks grants, ptr restarts at 0
        do_reset();
        req_i = 4'b0001;
        exp_q.push_back(0);
        step();
        check_grant("v6_pre");
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        req_i  = 4'b0011;
        exp_q.push_back(1);
        wait_grant("v6_busy", n);
        reset_i = 1'b0;
        step();
        check_zero("v6_reset");
        enable_i = 1'b0;
        step();
        reset_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("v6_disabled%0d", i), 32'(gnt_o), 32'd0);
        end
        enable_i = 1'b1;
        exp_q.push_back(0);
        step();
        check_grant("v6_restart");
        finish_grant();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
